// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among ALU, load and JAL
// writeback sources, with a destination-register scoreboard for decode hazard detection.
module regfile_wb_arbiter #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int LINK_REG = 31
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_wd,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [AW-1:0] mem_rd,
  input  logic [DW-1:0] mem_wd,
  input  logic          jal_valid,
  output logic          jal_ready,
  input  logic [DW-1:0] jal_wd,
  input  logic          rsv_en,
  input  logic [AW-1:0] rsv_rd,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  output logic          hz_a,
  output logic          hz_b,
  output logic          rf_we,
  output logic [AW-1:0] rf_rd,
  output logic [DW-1:0] rf_wd
);

  // state   | meaning
  // PTR_ALU | search order ALU, MEM, JAL
  // PTR_MEM | search order MEM, JAL, ALU
  // PTR_JAL | search order JAL, ALU, MEM
  typedef enum logic [1:0] {
    PTR_ALU = 2'd0,
    PTR_MEM = 2'd1,
    PTR_JAL = 2'd2
  } ptr_t;

  localparam logic [AW-1:0] LINK = AW'(LINK_REG);

  ptr_t             ptr, ptr_next;
  logic [2**AW-1:0] sb, sb_next;
  logic             grant_alu, grant_mem, grant_jal;
  logic             fire;
  logic [AW-1:0]    win_rd;
  logic [DW-1:0]    win_wd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= PTR_ALU;
    else        ptr <= ptr_next;
  end

  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    grant_jal = 1'b0;
    ptr_next  = ptr;
    case (ptr)
      PTR_MEM: begin
        if (mem_valid)      grant_mem = 1'b1;
        else if (jal_valid) grant_jal = 1'b1;
        else if (alu_valid) grant_alu = 1'b1;
      end
      PTR_JAL: begin
        if (jal_valid)      grant_jal = 1'b1;
        else if (alu_valid) grant_alu = 1'b1;
        else if (mem_valid) grant_mem = 1'b1;
      end
      default: begin
        if (alu_valid)      grant_alu = 1'b1;
        else if (mem_valid) grant_mem = 1'b1;
        else if (jal_valid) grant_jal = 1'b1;
      end
    endcase
    if (grant_alu) ptr_next = PTR_MEM;
    if (grant_mem) ptr_next = PTR_JAL;
    if (grant_jal) ptr_next = PTR_ALU;
  end

  // readies are forced low while reset is asserted, independent of the clock
  assign alu_ready = grant_alu & rst_n;
  assign mem_ready = grant_mem & rst_n;
  assign jal_ready = grant_jal & rst_n;
  assign fire      = grant_alu | grant_mem | grant_jal;

  always_comb begin
    win_rd = alu_rd;
    win_wd = alu_wd;
    if (grant_mem) begin
      win_rd = mem_rd;
      win_wd = mem_wd;
    end
    if (grant_jal) begin
      win_rd = LINK;
      win_wd = jal_wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we <= 1'b0;
      rf_rd <= '0;
      rf_wd <= '0;
    end else if (fire) begin
      rf_we <= (win_rd != '0);
      rf_rd <= win_rd;
      rf_wd <= win_wd;
    end else begin
      rf_we <= 1'b0;
    end
  end

  // clear before set so a same-edge reservation of the retiring register survives
  always_comb begin
    sb_next = sb;
    if (fire) sb_next[win_rd] = 1'b0;
    if (rsv_en && (rsv_rd != '0)) sb_next[rsv_rd] = 1'b1;
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb <= '0;
    else        sb <= sb_next;
  end

  assign hz_a = (rs != '0) & sb[rs];
  assign hz_b = (rt != '0) & sb[rt];

endmodule
